// File: rtl/mhd_stream_monitor_if.sv
// rtl/mhd_stream_monitor_if.sv - operand/result handshake and statistics bundle for mhd_stream_monitor
interface mhd_stream_monitor_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  localparam int HD_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [HD_W-1:0]  hd;
  logic             viol;
  logic             clear;
  logic [CNT_W-1:0] viol_cnt;
  logic [HD_W-1:0]  max_hd;

  modport master (
    output in_valid, a, b, out_ready, clear,
    input  in_ready, out_valid, hd, viol, viol_cnt, max_hd
  );

  modport slave (
    input  in_valid, a, b, out_ready, clear,
    output in_ready, out_valid, hd, viol, viol_cnt, max_hd
  );
endinterface

// File: rtl/mhd_stream_monitor.sv
// rtl/mhd_stream_monitor.sv - sliced Hamming-distance checker with threshold and optional statistics (MHD_STATS_EN)
module mhd_stream_monitor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int MHD   = 4,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  mhd_stream_monitor_if.slave mon
);
  localparam int NCH   = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PAD_W = NCH * CHUNK;
  localparam int HD_W  = $clog2(WIDTH + 1);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state, state_nxt;
  logic [PAD_W-1:0] diff, diff_in;
  logic [IDX_W-1:0] idx;
  logic [HD_W-1:0]  acc, slice_pop;
  logic             accept, done_hs, last_slice;

  // Zero-extend to a whole number of slices so the final partial slice pops only real bits.
  always_comb begin
    diff_in = '0;
    diff_in[WIDTH-1:0] = mon.a ^ mon.b;
  end

  // diff is shifted down each ACC cycle, so the current slice is always the low CHUNK bits.
  always_comb begin
    slice_pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      slice_pop = slice_pop + HD_W'(diff[i]);
    end
  end

  assign last_slice = (idx == IDX_W'(NCH - 1));
  assign accept     = (state == IDLE) && mon.in_valid;
  assign done_hs    = (state == DONE) && mon.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    mon.in_ready  = 1'b0;
    mon.out_valid = 1'b0;
    case (state)
      IDLE: begin
        mon.in_ready = 1'b1;
        if (mon.in_valid) state_nxt = ACC;
      end
      ACC: begin
        if (last_slice) state_nxt = DONE;
      end
      DONE: begin
        mon.out_valid = 1'b1;
        if (mon.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff <= '0;
      idx  <= '0;
      acc  <= '0;
    end else if (accept) begin
      diff <= diff_in;
      idx  <= '0;
      acc  <= '0;
    end else if (state == ACC) begin
      diff <= diff >> CHUNK;
      idx  <= idx + 1'b1;
      acc  <= acc + slice_pop;
    end
  end

  assign mon.hd   = acc;
  assign mon.viol = (acc > HD_W'(MHD));

`ifdef MHD_STATS_EN
  logic [CNT_W-1:0] cnt_q;
  logic [HD_W-1:0]  max_q;

  // clear wins over a same-cycle handshake: that result is delivered but not counted.
  always_ff @(posedge clk) begin
    if (!rst_n || mon.clear) begin
      cnt_q <= '0;
      max_q <= '0;
    end else if (done_hs) begin
      if (mon.viol && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
      if (acc > max_q) max_q <= acc;
    end
  end

  assign mon.viol_cnt = cnt_q;
  assign mon.max_hd   = max_q;
`else
  logic unused_stats;
  assign unused_stats = mon.clear ^ done_hs;
  assign mon.viol_cnt = '0;
  assign mon.max_hd   = '0;
`endif
endmodule

// File: doc/mhd_stream_monitor.md
# mhd_stream_monitor

Sequential, parametrised Hamming-distance checker for approximate-circuit miters. It accepts word pairs (a, b) over a valid/ready handshake and popcounts a^b in CHUNK-bit slices, one slice per cycle. Each result is compared against the MHD threshold and delivered on a second valid/ready handshake. Running violation statistics are kept across words, so a testbench or on-chip monitor can stream many exact/approximate output pairs through one instance.

## Interface
- WIDTH, 32: operand width in bits, ≥1.
- CHUNK, 8: bits popcounted per cycle, 1..WIDTH.
- MHD, 4: threshold; a word violates when hd > MHD.
- CNT_W, 16: violation-counter width.
- Derived: NCH = ceil(WIDTH/CHUNK); HD_W = clog2(WIDTH+1).

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- a  in  WIDTH  exact output word.
- b  in  WIDTH  approximate output word.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- hd  out  HD_W  Hamming distance of the current result.
- viol  out  1  hd > MHD.
- clear  in  1  synchronous clear of statistics.
- viol_cnt  out  CNT_W  number of violating results consumed, saturating.
- max_hd  out  HD_W  largest hd consumed since reset/clear.

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch diff=a^b, acc=0, idx=0, go to ACC.
- ACC:
  - in_ready=0.
  - Each cycle, acc += popcount(diff[idx*CHUNK +: CHUNK]).
  - Bits at or above WIDTH in the final partial slice count as 0.
  - idx increments each cycle; after slice NCH-1 is added, go to DONE.
- DONE:
  - out_valid=1; hd=acc; viol=(acc>MHD), unsigned compare at HD_W bits.
  - Outputs stay stable while out_ready=0.
  - On out_ready: go to IDLE, and update statistics when MHD_STATS_EN is defined.
    - viol_cnt += viol, saturating at 2^CNT_W-1.
    - max_hd = max(max_hd, hd).
- acc is HD_W bits wide and never overflows.
- clear takes priority over a same-cycle DONE handshake:
  - viol_cnt and max_hd become 0.
  - That result is still delivered, but is not counted.
- clear does not affect the FSM or the in-flight word.
- Single-entry design: no new pair is accepted until the result is consumed. No overlap, no bypass.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE, in_ready=1, out_valid=0.
  - hd=0, viol=0, viol_cnt=0, max_hd=0, diff=0, idx=0.
- Reset during ACC or DONE abandons the word; no result is produced.
- Acceptance edge E0: in_valid & in_ready.
  - out_valid is first high after edge E0+NCH, a latency of NCH cycles (4 at defaults).
- With out_ready held high: one result per NCH+2 cycles.
  - A new pair is accepted in the IDLE cycle following the DONE handshake edge.
- in_valid is ignored outside IDLE.
- a and b are sampled only at E0.
- Statistics update on the DONE handshake edge and are visible the next cycle.

## Configuration
- MHD_STATS_EN:
  - Defined: viol_cnt and max_hd are implemented and clear is honoured.
  - Undefined: no statistics registers; viol_cnt and max_hd are tied to 0; clear is ignored.
  - hd, viol and the handshakes are identical in both builds.

## Test plan
- Zero distance: a=b=0x1234_5678, out_ready=1.
  - Required: out_valid 4 cycles after E0, hd=0, viol=0, viol_cnt=0.
- Threshold boundary:
  - a=0, b=0x0000_000F → hd=4, viol=0.
  - Then b=0x8000_000F → hd=5, viol=1, viol_cnt=1, max_hd=5.
- Full distance and back-pressure: a=0xFFFF_FFFF, b=0, out_ready low for 3 cycles.
  - Required: hd=32 held stable, in_ready=0 throughout.
  - After handshake: max_hd=32, in_ready=1 the next cycle.
- Partial slice: WIDTH=10, CHUNK=4, a=0x3FF, b=0.
  - Required: NCH=3, hd=10, latency 3.
- Saturation and clear: CNT_W=2, five words each with hd=6.
  - Required: viol_cnt=3.
  - Then clear asserted with the next DONE handshake: result delivered, viol_cnt=0, max_hd=0 afterwards.
- Reset mid-operation: rst_n=0 for one cycle during ACC.
  - Required: out_valid=0, in_ready=1, and all statistics 0 on the following cycle.
  - The next pair completes normally.
